// File: rtl/adc_mon_pkg.sv
// Shared phase codes and sizing helpers for the ADC phase-completion monitor.
package adc_mon_pkg;

  typedef enum logic [1:0] {
    PH_RAMP_UP = 2'b00,
    PH_HOLD_HI = 2'b01,
    PH_RAMP_DN = 2'b10,
    PH_HOLD_LO = 2'b11
  } phase_e;

  // Timer must hold the larger of the hold length and the ramp timeout.
  function automatic int timer_w(input int hold_cycles, input int timeout);
    int m;
    m = (hold_cycles > timeout) ? hold_cycles : timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/adc_phase_monitor_if.sv
// Phase/count inputs and completion/error outputs of the phase monitor.
interface adc_phase_monitor_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       status_in;
  logic [CNT_W-1:0] count_in;
  logic             err_clr;
  logic             status_change;
  logic             done_pulse;
  logic             phase_err;
  logic             timeout_err;

  modport master (
    output status_in, count_in, err_clr,
    input  status_change, done_pulse, phase_err, timeout_err
  );

  modport slave (
    input  status_in, count_in, err_clr,
    output status_change, done_pulse, phase_err, timeout_err
  );
endinterface

// File: rtl/adc_mon_cmp.sv
// Ramp threshold compare, widened by one bit so base +/- STEP never wraps.
module adc_mon_cmp #(
  parameter int CNT_W = 16,
  parameter int STEP  = 100
) (
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] base_i,
  input  logic             down_i,
  output logic             met_o,
  output logic             dir_err_o
);

  localparam logic [CNT_W:0] STEP_X = (CNT_W+1)'(STEP);

  logic [CNT_W:0] cnt_x;
  logic [CNT_W:0] base_x;
  logic [CNT_W:0] up_thr;
  logic [CNT_W:0] dn_thr;
  logic           met_up;
  logic           met_dn;

  assign cnt_x  = {1'b0, count_i};
  assign base_x = {1'b0, base_i};
  // An up threshold above the count range is simply never reached.
  assign up_thr = base_x + STEP_X;
  assign dn_thr = base_x - STEP_X;

  assign met_up = (cnt_x >= up_thr);
  assign met_dn = (base_x >= STEP_X) && (cnt_x <= dn_thr);

  assign met_o     = down_i ? met_dn : met_up;
  assign dir_err_o = down_i ? (count_i > base_i) : (count_i < base_i);

endmodule

// File: rtl/adc_phase_monitor.sv
// Flags completion of each ramp/hold phase of the ADC bench, with sticky
// direction and timeout errors.
module adc_phase_monitor
  import adc_mon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int STEP        = 100,
  parameter int HOLD_CYCLES = 100,
  parameter int TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  adc_phase_monitor_if.slave bus
);

  localparam int TMR_W = timer_w(HOLD_CYCLES, TIMEOUT);
  localparam logic [TMR_W-1:0] HOLD_T = TMR_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0] TMO_T  = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMO_M1 = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] ONE_T  = TMR_W'(1);

  phase_e           status;
  logic             entry;
  logic             is_ramp;
  logic             cmp_met;
  logic             cmp_dir_err;
  logic             sc_next;
  logic             dir_set;
  logic             tmo_set;

  logic             armed_q,         armed_d;
  phase_e           prev_status_q,   prev_status_d;
  logic [CNT_W-1:0] base_q,          base_d;
  logic [TMR_W-1:0] timer_q,         timer_d;
  logic             done_seen_q,     done_seen_d;
  logic             status_change_q, status_change_d;
  logic             done_pulse_q,    done_pulse_d;
  logic             phase_err_q,     phase_err_d;
  logic             timeout_err_q,   timeout_err_d;

  assign status  = phase_e'(bus.status_in);
  assign is_ramp = (status == PH_RAMP_UP) || (status == PH_RAMP_DN);
  assign entry   = !armed_q || (status != prev_status_q);

  adc_mon_cmp #(
    .CNT_W (CNT_W),
    .STEP  (STEP)
  ) u_cmp (
    .count_i   (bus.count_in),
    .base_i    (base_q),
    .down_i    (status == PH_RAMP_DN),
    .met_o     (cmp_met),
    .dir_err_o (cmp_dir_err)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    armed_d       = armed_q;
    prev_status_d = prev_status_q;
    base_d        = base_q;
    timer_d       = timer_q;
    sc_next       = 1'b0;
    dir_set       = 1'b0;
    tmo_set       = 1'b0;

    if (entry) begin
      armed_d       = 1'b1;
      prev_status_d = status;
      base_d        = bus.count_in;
      timer_d       = '0;
    end else if (is_ramp) begin
      sc_next = cmp_met;
      dir_set = cmp_dir_err;
      // Ramp timer freezes once the phase has completed at least once.
      if (!done_seen_q) begin
        tmo_set = (timer_q == TMO_M1) && !cmp_met;
        if (timer_q != TMO_T) timer_d = timer_q + ONE_T;
      end
    end else begin
      sc_next = (timer_q == HOLD_T);
      if (timer_q != HOLD_T) timer_d = timer_q + ONE_T;
    end

    status_change_d = sc_next;
    done_pulse_d    = sc_next && !done_seen_q;
    done_seen_d     = entry ? 1'b0 : (done_seen_q || sc_next);
    // A new error on the clearing edge takes priority over the clear.
    phase_err_d     = dir_set || (phase_err_q   && !bus.err_clr);
    timeout_err_d   = tmo_set || (timeout_err_q && !bus.err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q         <= 1'b0;
      prev_status_q   <= PH_RAMP_UP;
      base_q          <= '0;
      timer_q         <= '0;
      done_seen_q     <= 1'b0;
      status_change_q <= 1'b0;
      done_pulse_q    <= 1'b0;
      phase_err_q     <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      armed_q         <= armed_d;
      prev_status_q   <= prev_status_d;
      base_q          <= base_d;
      timer_q         <= timer_d;
      done_seen_q     <= done_seen_d;
      status_change_q <= status_change_d;
      done_pulse_q    <= done_pulse_d;
      phase_err_q     <= phase_err_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign bus.status_change = status_change_q;
  assign bus.done_pulse    = done_pulse_q;
  assign bus.phase_err     = phase_err_q;
  assign bus.timeout_err   = timeout_err_q;

endmodule

// File: doc/adc_phase_monitor.md
# adc_phase_monitor

Parametrised phase-completion monitor for the ADC forward-path bench. Tracks a 2-bit phase code (ramp up, hold high, ramp down, hold low) and the converter count value, and signals when each phase has met its completion criterion. Ramp phases complete on a count excursion of STEP from the phase-entry value; hold phases complete after HOLD_CYCLES clocks. Adds configurable width and thresholds, overflow-safe comparison, a per-phase completion pulse, sticky direction and timeout errors, and asynchronous reset.

## Interface
- CNT_W, 16, width of count_in
- STEP, 100, required count excursion in ramp phases (1 ≤ STEP < 2^CNT_W)
- HOLD_CYCLES, 100, hold-phase duration in clocks (≥ 1)
- TIMEOUT, 4096, max clocks a ramp phase may run without completing (> 1)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- status_in  in  2  phase code: 00 ramp up, 01 hold high, 10 ramp down, 11 hold low
- count_in  in  CNT_W  current converter count, unsigned
- err_clr  in  1  synchronous clear of sticky error flags
- status_change  out  1  level: current phase criterion met
- done_pulse  out  1  one-cycle pulse on first assertion of status_change per phase
- phase_err  out  1  sticky: count moved against ramp direction
- timeout_err  out  1  sticky: ramp phase exceeded TIMEOUT

## Operation
- Reset: all outputs 0, base 0, timer 0, armed 0, prev_status 00, done_seen 0.
- Phase entry edge E: armed==0, or status_in != prev_status. At E: base <= count_in, timer <= 0, done_seen <= 0, status_change <= 0, done_pulse <= 0, armed <= 1, prev_status <= status_in. No comparison at E.
- Ramp up (00), edges after E: status_change <= (count_in >= base + STEP); sum computed in CNT_W+1 bits, no wrap; if base + STEP > 2^CNT_W-1 criterion is unreachable. Level follows count_in (may drop back to 0).
- Ramp down (10): status_change <= (base >= STEP) && (count_in <= base - STEP); no underflow.
- Ramp direction error: 00 with count_in < base, or 10 with count_in > base, sets phase_err.
- Ramp timeout: timer increments each post-entry edge while done_seen==0, saturating; when timer reaches TIMEOUT-1 and criterion still unmet, timeout_err set. Timer stops once done_seen.
- Hold (01/11): timer increments each post-entry edge, saturating at HOLD_CYCLES; status_change <= (timer == HOLD_CYCLES), i.e. first asserted at edge E+HOLD_CYCLES+1, then stays 1 until next entry. count_in ignored; no errors raised.
- done_pulse <= status_change_next && !done_seen; done_seen set simultaneously.
- err_clr clears both sticky flags; a set condition on the same edge wins (flag stays 1).

## Timing
- All outputs registered; one cycle from sampled inputs to outputs.
- Ramp: count_in crossing sampled at edge N → status_change and done_pulse high after edge N.
- Phase change mid-completion: entry forces status_change 0 on that edge regardless of criterion.
- Reset mid-phase: immediate clear; first edge after release is an entry edge for current status_in.
- Single-cycle status_in glitches are legal and each cause two entries.

## Structure
- Package adc_mon_pkg: phase constants PH_RAMP_UP=2'b00, PH_HOLD_HI=2'b01, PH_RAMP_DN=2'b10, PH_HOLD_LO=2'b11; timer width function (clog2 of max(HOLD_CYCLES, TIMEOUT)+1).
- Sub-module adc_mon_cmp: combinational CNT_W+1-bit threshold compare (up/down, met, dir_err), instantiated once, selected by phase.

## Test plan
- Reset, status_in=00, count_in=1000; step count 1000→1099 → status_change 0; 1100 → status_change 1 and single done_pulse one edge later; count back to 1050 → status_change 0, no second pulse.
- status_in 00→01 at edge E, count static → status_change 0 until edge E+101 (HOLD_CYCLES=100), then held 1; done_pulse once.
- status_in=10, base 50, STEP 100 → never completes; phase_err stays 0; timeout_err set after 4096 clocks (TIMEOUT=4096).
- status_in=00, base 65500, CNT_W=16 → no wrap, status_change never 1, timeout_err set; then err_clr with concurrent timeout condition absent → flag clears.
- status_in=00, base 500, count drops to 499 → phase_err 1, persists across phase changes until err_clr.
- Assert rst_n low mid hold at timer 60 → all outputs 0 asynchronously; release, status_in=01 → completion at entry+101.
